// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and default widths for the SDRAM read arbiter
package sdram_arb_pkg;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W = 9;
  localparam int STRIDE_W = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} arbState_e;
endpackage

// File: rtl/sdram_burst_seq.sv
// sdram_burst_seq: per-burst address generation, issue/receive counting and data timeout
module sdram_burst_seq
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                SDRAM_CLK,
  input  logic                nReset,
  input  logic                load,
  input  logic [ADDR_W-1:0]   loadAddr,
  input  logic [LEN_W-1:0]    loadLen,
  input  logic [STRIDE_W-1:0] loadStride,
  input  logic                issuing,
  input  logic                active,
  input  logic                addressAck,
  input  logic                readDataValid,
  output logic                readReq,
  output logic [ADDR_W-1:0]   address,
  output logic                allIssued,
  output logic                allReceived,
  output logic                wordTaken,
  output logic                timeout
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [LEN_W-1:0] len, issued, received;
  logic [STRIDE_W-1:0] stride;
  logic [TO_W-1:0] quiet;
  assign readReq = issuing && (issued < len);
  assign allIssued = issued == len;
  assign allReceived = received == len;
  // words beyond the burst length are not ours; the top flags them as stray
  assign wordTaken = active && readDataValid && !allReceived;
  assign timeout = active && !readDataValid && (quiet == TO_W'(TIMEOUT - 1));
  always_ff @(posedge SDRAM_CLK or negedge nReset)
    if (!nReset) begin
      address <= '0;
      len <= '0;
      stride <= '0;
      issued <= '0;
      received <= '0;
      quiet <= '0;
    end else if (load) begin
      address <= loadAddr;
      len <= loadLen;
      stride <= loadStride;
      issued <= '0;
      received <= '0;
      quiet <= '0;
    end else begin
      if (readReq && addressAck) begin
        address <= address + ADDR_W'(stride);
        issued <= issued + LEN_W'(1);
      end
      if (wordTaken) received <= received + LEN_W'(1);
      quiet <= (active && !readDataValid) ? quiet + TO_W'(1) : '0;
    end
endmodule

// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter: two-requester burst read arbiter sharing one SDRAM read port,
// with bounded requester-0 priority and per-burst data routing.
module sdram_read_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                SDRAM_CLK,
  input  logic                nReset,
  input  logic [1:0]          reqValid,
  input  logic [ADDR_W-1:0]   reqAddr0,
  input  logic [ADDR_W-1:0]   reqAddr1,
  input  logic [LEN_W-1:0]    reqLen0,
  input  logic [LEN_W-1:0]    reqLen1,
  input  logic [STRIDE_W-1:0] reqStride0,
  input  logic [STRIDE_W-1:0] reqStride1,
  output logic [1:0]          grant,
  output logic [1:0]          rdValid,
  output logic [DATA_W-1:0]   rdData,
  output logic [1:0]          done,
  output logic                error,
  output logic                readReq,
  output logic [ADDR_W-1:0]   address,
  input  logic                addressAck,
  input  logic                readDataValid,
  input  logic [DATA_W-1:0]   readData
);
  localparam int CNT_W = $clog2(MAX_CONSEC + 2);
  arbState_e state;
  logic owner, pick1, load, allIssued, allReceived, wordTaken, timeout;
  logic [CNT_W-1:0] consec;
  logic [1:0] ownerHot;
  // requester 1 is starved for at most MAX_CONSEC requester-0 bursts
  assign pick1 = reqValid[1] && (!reqValid[0] || consec == CNT_W'(MAX_CONSEC));
  assign load = (state == IDLE) && |reqValid;
  assign ownerHot = owner ? 2'b10 : 2'b01;
  sdram_burst_seq #(
    .ADDR_W(ADDR_W),
    .LEN_W(LEN_W),
    .TIMEOUT(TIMEOUT)
  ) seq (
    .SDRAM_CLK(SDRAM_CLK),
    .nReset(nReset),
    .load(load),
    .loadAddr(pick1 ? reqAddr1 : reqAddr0),
    .loadLen(pick1 ? reqLen1 : reqLen0),
    .loadStride(pick1 ? reqStride1 : reqStride0),
    .issuing(state == ISSUE),
    .active(state == ISSUE || state == DRAIN),
    .addressAck(addressAck),
    .readDataValid(readDataValid),
    .readReq(readReq),
    .address(address),
    .allIssued(allIssued),
    .allReceived(allReceived),
    .wordTaken(wordTaken),
    .timeout(timeout)
  );
  always_ff @(posedge SDRAM_CLK or negedge nReset)
    if (!nReset) begin
      state <= IDLE;
      owner <= 1'b0;
      consec <= '0;
      grant <= '0;
      rdValid <= '0;
      rdData <= '0;
      done <= '0;
      error <= 1'b0;
    end else begin
      grant <= '0;
      done <= '0;
      rdValid <= wordTaken ? ownerHot : 2'b00;
      if (wordTaken) rdData <= readData;
      if (timeout || (readDataValid && !wordTaken)) error <= 1'b1;
      if (!reqValid[1]) consec <= '0;
      case (state)
        IDLE: if (load) begin
          state <= ISSUE;
          owner <= pick1;
          grant <= pick1 ? 2'b10 : 2'b01;
          if (pick1) consec <= '0;
          else if (reqValid[1]) consec <= consec + CNT_W'(1);
        end
        ISSUE: if (timeout) begin
          state <= DONE;
          done <= ownerHot;
        end else if (allIssued) state <= DRAIN;
        DRAIN: if (timeout || allReceived) begin
          state <= DONE;
          done <= ownerHot;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb_sdram_read_arbiter: directed bench with a 3-cycle-latency SDRAM model and
// hand-computed expectations for bursts, arbitration, timeout and reset.
module tb_sdram_read_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int LEN_W = 9;
  logic SDRAM_CLK = 1'b0;
  logic nReset = 1'b0;
  logic [1:0] reqValid = '0;
  logic [ADDR_W-1:0] reqAddr0 = '0, reqAddr1 = '0;
  logic [LEN_W-1:0] reqLen0 = '0, reqLen1 = '0;
  logic [1:0] reqStride0 = 2'd1, reqStride1 = 2'd1;
  logic [1:0] grant, rdValid, done;
  logic [DATA_W-1:0] rdData;
  logic error, readReq;
  logic [ADDR_W-1:0] address;
  logic addressAck = 1'b1;
  logic readDataValid = 1'b0;
  logic [DATA_W-1:0] readData = '0;
  int vecCnt = 0, missCnt = 0, cyc = 0;
  logic [ADDR_W-1:0] addrLog[$];
  logic [DATA_W-1:0] expData[$];
  logic [DATA_W:0] pipe[3] = '{default: '0};
  int rdv0 = 0, rdv1 = 0, done0 = 0, done1 = 0, dataErr = 0, retCnt = 0;
  int retLimit = 1 << 30;

  sdram_read_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_CONSEC(4), .TIMEOUT(1024)
  ) dut (
    .SDRAM_CLK(SDRAM_CLK), .nReset(nReset), .reqValid(reqValid),
    .reqAddr0(reqAddr0), .reqAddr1(reqAddr1), .reqLen0(reqLen0), .reqLen1(reqLen1),
    .reqStride0(reqStride0), .reqStride1(reqStride1), .grant(grant), .rdValid(rdValid),
    .rdData(rdData), .done(done), .error(error), .readReq(readReq), .address(address),
    .addressAck(addressAck), .readDataValid(readDataValid), .readData(readData)
  );

  always #5 SDRAM_CLK = ~SDRAM_CLK;
  always @(posedge SDRAM_CLK) cyc++;

  // SDRAM model and output monitor, both on the falling edge
  always @(negedge SDRAM_CLK) begin
    if (|rdValid) begin
      rdv0 += int'(rdValid[0]);
      rdv1 += int'(rdValid[1]);
      if (expData.size() == 0 || rdData !== expData[0]) dataErr++;
      if (expData.size() != 0) void'(expData.pop_front());
    end
    done0 += int'(done[0]);
    done1 += int'(done[1]);
    {readDataValid, readData} = pipe[2];
    if (readDataValid) expData.push_back(readData);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = '0;
    if (readReq && addressAck) begin
      addrLog.push_back(address);
      if (retCnt < retLimit) begin
        pipe[0] = {1'b1, address[DATA_W-1:0] ^ 16'h5A3C};
        retCnt++;
      end
    end
  end

  task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      missCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic runBurst(input int who, input logic [ADDR_W-1:0] a, input int len,
                          input int stride, output int lat, output logic rrDone);
    int n, t0;
    if (who == 0) begin
      reqAddr0 = a; reqLen0 = LEN_W'(len); reqStride0 = 2'(stride);
    end else begin
      reqAddr1 = a; reqLen1 = LEN_W'(len); reqStride1 = 2'(stride);
    end
    reqValid[who] = 1'b1;
    n = 0;
    do begin @(posedge SDRAM_CLK); #1; n++; end while (grant[who] !== 1'b1 && n < 20);
    checkVec("grant", 32'(grant), who == 1 ? 32'h2 : 32'h1);
    reqValid = '0;
    t0 = cyc;
    n = 0;
    do begin @(posedge SDRAM_CLK); #1; n++; end while (done[who] !== 1'b1 && n < 3000);
    checkVec("doneSeen", 32'(done), who == 1 ? 32'h2 : 32'h1);
    lat = cyc - t0;
    rrDone = readReq;
    repeat (3) @(posedge SDRAM_CLK);
    #1;
  endtask

  task automatic checkRun(input string tag, input int base, input int n,
                          input logic [ADDR_W-1:0] first, input int stride);
    int bad = 0;
    checkVec({tag, ".count"}, 32'(addrLog.size() - base), 32'(n));
    if (n > 0 && addrLog.size() > base) begin
      checkVec({tag, ".first"}, 32'(addrLog[base]), 32'(first));
      for (int i = 1; i < n && base + i < addrLog.size(); i++)
        if (addrLog[base+i] !== addrLog[base+i-1] + ADDR_W'(stride)) bad++;
      checkVec({tag, ".step"}, 32'(bad), 0);
    end
  endtask

  initial begin
    int lat, b0, v0, v1, d0, d1, de, k, n;
    logic rr;
    logic [9:0] order;
    repeat (3) @(posedge SDRAM_CLK);
    #1;
    checkVec("rst.readReq", 32'(readReq), 0);
    checkVec("rst.grant", 32'(grant), 0);
    checkVec("rst.rdValid", 32'(rdValid), 0);
    checkVec("rst.done", 32'(done), 0);
    checkVec("rst.error", 32'(error), 0);
    checkVec("rst.address", 32'(address), 0);
    checkVec("rst.rdData", 32'(rdData), 0);
    nReset = 1'b1;
    repeat (2) @(posedge SDRAM_CLK);
    #1;
    b0 = addrLog.size(); v0 = rdv0; d0 = done0; de = dataErr;
    runBurst(0, 24'h000801, 128, 1, lat, rr);
    checkRun("len128", b0, 128, 24'h000801, 1);
    checkVec("len128.last", 32'(addrLog[$]), 32'h000880);
    checkVec("len128.rdv0", 32'(rdv0 - v0), 128);
    checkVec("len128.done0", 32'(done0 - d0), 1);
    checkVec("len128.lat", 32'(lat), 132);
    checkVec("len128.data", 32'(dataErr - de), 0);
    checkVec("len128.error", 32'(error), 0);
    b0 = addrLog.size(); v1 = rdv1; d1 = done1; de = dataErr;
    runBurst(1, 24'h000100, 64, 2, lat, rr);
    checkRun("stride2", b0, 64, 24'h000100, 2);
    checkVec("stride2.last", 32'(addrLog[$]), 32'h00017E);
    checkVec("stride2.rdv1", 32'(rdv1 - v1), 64);
    checkVec("stride2.done1", 32'(done1 - d1), 1);
    checkVec("stride2.lat", 32'(lat), 68);
    checkVec("stride2.data", 32'(dataErr - de), 0);
    v0 = rdv0; v1 = rdv1; d0 = done0; d1 = done1;
    reqAddr0 = 24'h001000; reqAddr1 = 24'h001800;
    reqLen0 = 9'd4; reqLen1 = 9'd4; reqStride0 = 2'd1; reqStride1 = 2'd1;
    reqValid = 2'b11;
    order = '0; k = 0; n = 0;
    while (k < 10 && n < 500) begin
      @(posedge SDRAM_CLK);
      #1;
      n++;
      if (|grant) begin
        order[k] = grant[1];
        k++;
        if (k == 10) reqValid = '0;
      end
    end
    reqValid = '0;
    checkVec("arb.grants", 32'(k), 10);
    checkVec("arb.order", 32'(order), 32'b1000010000);
    repeat (40) @(posedge SDRAM_CLK);
    #1;
    checkVec("arb.done0", 32'(done0 - d0), 8);
    checkVec("arb.done1", 32'(done1 - d1), 2);
    checkVec("arb.rdv0", 32'(rdv0 - v0), 32);
    checkVec("arb.rdv1", 32'(rdv1 - v1), 8);
    checkVec("arb.error", 32'(error), 0);
    b0 = addrLog.size(); d0 = done0;
    runBurst(0, 24'h000400, 0, 1, lat, rr);
    checkRun("len0", b0, 0, 24'h000400, 1);
    checkVec("len0.lat", 32'(lat), 2);
    checkVec("len0.done0", 32'(done0 - d0), 1);
    b0 = addrLog.size(); v0 = rdv0; d0 = done0;
    retLimit = retCnt + 2;
    runBurst(0, 24'h002000, 8, 1, lat, rr);
    retLimit = 1 << 30;
    checkVec("tmo.issued", 32'(addrLog.size() - b0), 8);
    checkVec("tmo.rdv0", 32'(rdv0 - v0), 2);
    checkVec("tmo.lat", 32'(lat), 1029);
    checkVec("tmo.readReq", 32'(rr), 0);
    checkVec("tmo.error", 32'(error), 1);
    checkVec("tmo.done0", 32'(done0 - d0), 1);
    reqAddr0 = 24'h003000; reqLen0 = 9'd8; reqStride0 = 2'd1;
    reqValid = 2'b01;
    n = 0;
    do begin @(posedge SDRAM_CLK); #1; n++; end while (grant[0] !== 1'b1 && n < 20);
    checkVec("rstb.grant", 32'(grant), 1);
    reqValid = '0;
    repeat (9) @(posedge SDRAM_CLK);
    #1;
    v0 = rdv0; d0 = done0;
    nReset = 1'b0;
    #1;
    checkVec("rstb.readReq", 32'(readReq), 0);
    checkVec("rstb.grant", 32'(grant), 0);
    checkVec("rstb.rdValid", 32'(rdValid), 0);
    checkVec("rstb.done", 32'(done), 0);
    checkVec("rstb.error", 32'(error), 0);
    checkVec("rstb.address", 32'(address), 0);
    checkVec("rstb.rdData", 32'(rdData), 0);
    #1;
    nReset = 1'b1;
    repeat (4) @(posedge SDRAM_CLK);
    #1;
    checkVec("rstb.strayError", 32'(error), 1);
    checkVec("rstb.noDone", 32'(done0 - d0), 0);
    checkVec("rstb.noRdv", 32'(rdv0 - v0), 0);
    checkVec("rstb.readReqIdle", 32'(readReq), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end
endmodule
